// File: rtl/riscv_wb.sv
// riscv_wb: write-back stage with zero-latency load completion and a
// one-entry buffer for data responses that arrive ahead of their load.
module riscv_wb #(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wb_stall_i,
   output logic            wb_stall_o,
   input  logic [XLEN-1:0] wb_pc_i,
   output logic [XLEN-1:0] wb_pc_o,
   input  logic [31:0]     wb_instr_i,
   input  logic            wb_bubble_i,
   input  logic            wb_exception_i,
   input  logic [XLEN-1:0] wb_r_i,
   input  logic [XLEN-1:0] wb_memadr_i,
   input  logic            dmem_ack_i,
   input  logic            dmem_err_i,
   input  logic [XLEN-1:0] dmem_q_i,
   output logic [4:0]      rf_dst_o,
   output logic            rf_we_o,
   output logic [XLEN-1:0] rf_data_o,
   output logic            wb_exception_o,
   output logic [XLEN-1:0] wb_badaddr_o
);

   localparam int         OW      = $clog2(XLEN/8);
   localparam logic [6:0] OP_LOAD = 7'b0000011;

   typedef enum logic {IDLE, LWAIT} state_t;

   state_t          state_q, state_d;
   logic            valid_q, valid_d;
   logic [6:0]      opc_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] pc_q, r_q, adr_q;
   logic            ev_q, ev_d, eerr_q, eerr_d;
   logic [XLEN-1:0] edata_q, edata_d;
   logic            live, held_ld, avail, cap, go, consume;
   logic            new_valid, new_ld, resp_err;
   logic [XLEN-1:0] resp_q, shifted, ld_data;
   logic            unused_ok;

   assign live      = dmem_ack_i | dmem_err_i;
   assign held_ld   = valid_q && (opc_q == OP_LOAD);
   assign avail     = live | ev_q;
   assign new_valid = !wb_bubble_i && !wb_exception_i;
   assign new_ld    = wb_instr_i[6:0] == OP_LOAD;

   assign wb_stall_o = (state_q == LWAIT) && !live;
   assign cap        = !wb_stall_i && !wb_stall_o;
   assign go         = valid_q && !wb_stall_i && (!held_ld || avail);
   assign consume    = go && held_ld;

   // Buffered response is older than a live one, so it is used first.
   assign resp_err = ev_q ? eerr_q : dmem_err_i;
   assign resp_q   = ev_q ? edata_q : dmem_q_i;
   assign shifted  = resp_q >> {adr_q[OW-1:0], 3'b000};

   always_comb begin
      ld_data = shifted;
      unique case (f3_q)
         3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
         3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
         3'b010:  ld_data = XLEN'($signed(shifted[31:0]));
         3'b100:  ld_data = XLEN'(shifted[7:0]);
         3'b101:  ld_data = XLEN'(shifted[15:0]);
         3'b110:  ld_data = XLEN'(shifted[31:0]);
         default: ld_data = shifted;
      endcase
   end

   assign rf_we_o        = go && (rd_q != 5'd0) && !(held_ld && resp_err);
   assign wb_exception_o = consume && resp_err;
   assign rf_dst_o       = rd_q;
   assign rf_data_o      = held_ld ? ld_data : r_q;
   assign wb_badaddr_o   = adr_q;
   assign wb_pc_o        = pc_q;
   assign unused_ok      = ^wb_instr_i[31:15];

   always_comb begin
      ev_d    = ev_q;
      eerr_d  = eerr_q;
      edata_d = edata_q;
      if (consume && ev_q) begin
         ev_d    = live;
         eerr_d  = dmem_err_i;
         edata_d = dmem_q_i;
      end else if (!consume && live && !ev_q) begin
         ev_d    = 1'b1;
         eerr_d  = dmem_err_i;
         edata_d = dmem_q_i;
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (cap)
         valid_d = new_valid;
      else if (go)
         valid_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (cap && new_valid && new_ld && !ev_d)
               state_d = LWAIT;
         LWAIT:
            if (live)
               state_d = (cap && new_valid && new_ld && !ev_d) ? LWAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         ev_q    <= 1'b0;
         pc_q    <= PC_INIT;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ev_q    <= ev_d;
         if (cap)
            pc_q <= wb_pc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      eerr_q  <= eerr_d;
      edata_q <= edata_d;
      if (cap) begin
         opc_q <= wb_instr_i[6:0];
         f3_q  <= wb_instr_i[14:12];
         rd_q  <= wb_instr_i[11:7];
         r_q   <= wb_r_i;
         adr_q <= wb_memadr_i;
      end
   end

endmodule

// File: tb/tb_riscv_wb.sv
// tb_riscv_wb: directed table, corner sequences and random traffic
// checked against a queue-based write-back model.
module tb_riscv_wb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wb_stall_i;
   logic        wb_stall_o;
   logic [31:0] wb_pc_i, wb_pc_o;
   logic [31:0] wb_instr_i;
   logic        wb_bubble_i, wb_exception_i;
   logic [31:0] wb_r_i, wb_memadr_i;
   logic        dmem_ack_i, dmem_err_i;
   logic [31:0] dmem_q_i;
   logic [4:0]  rf_dst_o;
   logic        rf_we_o;
   logic [31:0] rf_data_o;
   logic        wb_exception_o;
   logic [31:0] wb_badaddr_o;

   riscv_wb dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wb_stall_i(wb_stall_i), .wb_stall_o(wb_stall_o),
      .wb_pc_i(wb_pc_i), .wb_pc_o(wb_pc_o),
      .wb_instr_i(wb_instr_i), .wb_bubble_i(wb_bubble_i),
      .wb_exception_i(wb_exception_i), .wb_r_i(wb_r_i),
      .wb_memadr_i(wb_memadr_i), .dmem_ack_i(dmem_ack_i),
      .dmem_err_i(dmem_err_i), .dmem_q_i(dmem_q_i),
      .rf_dst_o(rf_dst_o), .rf_we_o(rf_we_o), .rf_data_o(rf_data_o),
      .wb_exception_o(wb_exception_o), .wb_badaddr_o(wb_badaddr_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } resp_t;

   typedef struct {
      logic [31:0] instr, r, adr, q;
      int          dly;
      int          we;
      logic [31:0] data;
      int          stalls;
   } vec_t;

   resp_t       eq[$];
   logic        m_valid;
   logic [31:0] m_instr, m_r, m_adr, m_pc;
   logic [31:0] pc_cnt;
   int          n_cmp, n_bad;
   logic        a_we, a_stall, a_exc;
   logic [31:0] a_data, a_bad;
   vec_t        tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ld_val(logic [31:0] q, logic [31:0] adr, logic [2:0] f3);
      int unsigned v;
      v = q >> (8 * (adr % 4));
      case (f3)
         3'd0: begin v = v & 'hFF; if (v >= 128) v = v - 256; end
         3'd1: begin v = v & 'hFFFF; if (v >= 32768) v = v - 65536; end
         3'd4: v = v & 'hFF;
         3'd5: v = v & 'hFFFF;
         default: ;
      endcase
      return v;
   endfunction

   task automatic drv(input logic bub, input logic [31:0] instr, input logic [31:0] r,
                      input logic [31:0] adr, input logic ack, input logic err,
                      input logic [31:0] q);
      wb_bubble_i    = bub;
      wb_exception_i = 1'b0;
      wb_instr_i     = instr;
      wb_r_i         = r;
      wb_memadr_i    = adr;
      dmem_ack_i     = ack;
      dmem_err_i     = err;
      dmem_q_i       = q;
      wb_pc_i        = pc_cnt;
      pc_cnt         = pc_cnt + 4;
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_pc    = 32'h200;
      eq.delete();
   endtask

   task automatic step();
      logic ld, live, have, avail, e_stall, e_ret, e_we, e_exc, r_err, cap;
      logic [31:0] r_d, e_data;
      #2;
      ld      = m_valid && (m_instr[6:0] == 7'b0000011);
      live    = dmem_ack_i || dmem_err_i;
      have    = eq.size() > 0;
      avail   = live || have;
      e_stall = ld && !avail;
      e_ret   = m_valid && !wb_stall_i && (!ld || avail);
      r_err   = have ? eq[0].e : dmem_err_i;
      r_d     = have ? eq[0].d : dmem_q_i;
      e_we    = e_ret && (m_instr[11:7] != 0) && !(ld && r_err);
      e_exc   = e_ret && ld && r_err;
      e_data  = ld ? ld_val(r_d, m_adr, m_instr[14:12]) : m_r;
      chk("stall", {31'b0, wb_stall_o}, {31'b0, e_stall});
      chk("we", {31'b0, rf_we_o}, {31'b0, e_we});
      chk("exc", {31'b0, wb_exception_o}, {31'b0, e_exc});
      chk("pc", wb_pc_o, m_pc);
      if (e_we) begin
         chk("dst", {27'b0, rf_dst_o}, {27'b0, m_instr[11:7]});
         chk("data", rf_data_o, e_data);
      end
      if (e_exc) chk("badaddr", wb_badaddr_o, m_adr);
      a_we = rf_we_o; a_stall = wb_stall_o; a_exc = wb_exception_o;
      a_data = rf_data_o; a_bad = wb_badaddr_o;
      @(posedge clk_i);
      cap = !wb_stall_i && !e_stall;
      if (e_ret && ld && have) void'(eq.pop_front());
      if (live && !(e_ret && ld && !have) && eq.size() == 0)
         eq.push_back('{d: dmem_q_i, e: dmem_err_i});
      if (cap) begin
         m_valid = !wb_bubble_i && !wb_exception_i;
         m_instr = wb_instr_i;
         m_r     = wb_r_i;
         m_adr   = wb_memadr_i;
         m_pc    = wb_pc_i;
      end else if (e_ret) begin
         m_valid = 1'b0;
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset(input string nm);
      rst_i = 1'b1;
      drv(1'b1, 32'h13, 0, 0, 1'b0, 1'b0, 0);
      model_reset();
      #2;
      chk({nm, "_stall"}, {31'b0, wb_stall_o}, 32'd0);
      chk({nm, "_we"}, {31'b0, rf_we_o}, 32'd0);
      chk({nm, "_exc"}, {31'b0, wb_exception_o}, 32'd0);
      chk({nm, "_pc"}, wb_pc_o, 32'h200);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic bub(input logic ack, input logic err, input logic [31:0] q);
      drv(1'b1, 32'h13, 0, 0, ack, err, q);
      step();
   endtask

   initial begin
      int we_cnt, st_cnt;
      logic [31:0] got;
      logic [2:0] f3s[5];
      f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;
      tbl[0] = '{32'h0000_02B3, 32'h1234, 0, 0, 0, 1, 32'h1234, 0};
      tbl[1] = '{32'h0000_0183, 0, 32'h2, 32'h0080_0000, 3, 1, 32'hFFFF_FF80, 2};
      tbl[2] = '{32'h0000_5203, 0, 32'h2, 32'h8001_0000, 0, 1, 32'h0000_8001, 0};
      tbl[3] = '{32'h0000_2383, 0, 32'h40, 32'hDEAD_BEEF, 1, 1, 32'hDEAD_BEEF, 0};
      tbl[4] = '{32'h0000_1403, 0, 32'h2, 32'h8000_0000, 2, 1, 32'hFFFF_8000, 1};
      tbl[5] = '{32'h0000_4483, 0, 32'h3, 32'hF000_0000, 1, 1, 32'h0000_00F0, 0};
      tbl[6] = '{32'h0000_0503, 0, 32'h1, 32'h0000_7F00, 0, 1, 32'h0000_007F, 0};
      tbl[7] = '{32'h0000_0033, 32'h5, 0, 0, 0, 0, 0, 0};
      n_cmp = 0; n_bad = 0; pc_cnt = 32'h1000;
      wb_stall_i = 1'b0;
      rst_i = 1'b1;
      drv(1'b1, 32'h13, 0, 0, 1'b0, 1'b0, 0);
      @(negedge clk_i);
      do_reset("init");

      foreach (tbl[i]) begin
         we_cnt = 0; st_cnt = 0; got = 0;
         for (int c = 0; c < 7; c++) begin
            drv(c != 0, (c == 0) ? tbl[i].instr : 32'h13, tbl[i].r, tbl[i].adr,
                (tbl[i].instr[6:0] == 7'h03) && (c == tbl[i].dly), 1'b0, tbl[i].q);
            step();
            if (a_we) begin we_cnt++; got = a_data; end
            if (a_stall) st_cnt++;
         end
         chk($sformatf("tbl%0d_we", i), we_cnt, tbl[i].we);
         chk($sformatf("tbl%0d_stalls", i), st_cnt, tbl[i].stalls);
         if (tbl[i].we != 0) chk($sformatf("tbl%0d_data", i), got, tbl[i].data);
      end

      drv(1'b0, 32'h0000_02B3, 32'h1, 0, 1'b0, 1'b0, 0); step();
      drv(1'b0, 32'h0000_2303, 0, 0, 1'b1, 1'b0, 32'h55); step();
      chk("early_add_we", {31'b0, a_we}, 32'd1);
      bub(1'b0, 1'b0, 0);
      chk("early_we", {31'b0, a_we}, 32'd1);
      chk("early_data", a_data, 32'h55);
      chk("early_nostall", {31'b0, a_stall}, 32'd0);
      drv(1'b0, 32'h0000_2583, 32'h0, 32'h4, 1'b0, 1'b0, 0); step();
      bub(1'b0, 1'b0, 0);
      chk("early_cleared", {31'b0, a_stall}, 32'd1);
      bub(1'b1, 1'b0, 32'h99);
      chk("late_data", a_data, 32'h99);

      drv(1'b0, 32'h0000_2303, 0, 32'h100, 1'b0, 1'b0, 0); step();
      bub(1'b0, 1'b1, 32'hBAD);
      chk("err_exc", {31'b0, a_exc}, 32'd1);
      chk("err_we", {31'b0, a_we}, 32'd0);
      chk("err_badaddr", a_bad, 32'h100);
      bub(1'b0, 1'b0, 0);
      chk("err_pulse", {31'b0, a_exc}, 32'd0);

      bub(1'b1, 1'b0, 32'h11);
      bub(1'b1, 1'b0, 32'h22);
      drv(1'b0, 32'h0000_2383, 0, 0, 1'b0, 1'b0, 0); step();
      bub(1'b0, 1'b0, 0);
      chk("drop_keeps_old", a_data, 32'h11);

      drv(1'b0, 32'h0000_04B3, 32'hABCD, 0, 1'b0, 1'b0, 0); step();
      wb_stall_i = 1'b1;
      bub(1'b0, 1'b0, 0);
      chk("hold_we1", {31'b0, a_we}, 32'd0);
      bub(1'b0, 1'b0, 0);
      chk("hold_we2", {31'b0, a_we}, 32'd0);
      wb_stall_i = 1'b0;
      bub(1'b0, 1'b0, 0);
      chk("hold_rel_data", a_data, 32'hABCD);
      chk("hold_rel_we", {31'b0, a_we}, 32'd1);
      bub(1'b0, 1'b0, 0);
      chk("hold_once", {31'b0, a_we}, 32'd0);

      drv(1'b0, 32'h0000_2183, 0, 0, 1'b0, 1'b0, 0); step();
      bub(1'b0, 1'b0, 0);
      chk("rst_pre_stall", {31'b0, a_stall}, 32'd1);
      do_reset("mid");
      drv(1'b0, 32'h0000_0033, 32'h7, 0, 1'b0, 1'b0, 0); step();
      bub(1'b0, 1'b0, 0);
      chk("x0_we", {31'b0, a_we}, 32'd0);
      bub(1'b1, 1'b0, 32'h77);
      drv(1'b0, 32'h0000_2603, 0, 0, 1'b0, 1'b0, 0); step();
      bub(1'b0, 1'b0, 0);
      chk("post_rst_data", a_data, 32'h77);
      chk("post_rst_stall", {31'b0, a_stall}, 32'd0);

      for (int n = 0; n < 600; n++) begin
         logic [31:0] ins;
         ins = $urandom;
         if ($urandom_range(2) == 0)
            ins[6:0] = 7'b0110011;
         else begin
            ins[6:0]   = 7'b0000011;
            ins[14:12] = f3s[$urandom_range(4)];
         end
         wb_stall_i = ($urandom_range(3) == 0);
         drv($urandom_range(4) == 0, ins, $urandom, $urandom,
             $urandom_range(3) == 0, $urandom_range(11) == 0, $urandom);
         wb_exception_i = ($urandom_range(7) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
